// File: rtl/nor3_exerciser.sv
// Stimulus/response driver for a three-input NOR cell.
// Steps an 8-vector table, syncs Y back in, counts settle latency.
module nor3_exerciser #(
    parameter int CNT_W      = 4,
    parameter int SETTLE_MAX = 15
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             start,
    input  logic             y_in,
    output logic             drv_a,
    output logic             drv_b,
    output logic             drv_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       err_count,
    output logic [CNT_W-1:0] max_lat,
    output logic [2:0]       vec_idx
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAT_TMO = CNT_W'(SETTLE_MAX);

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_lat;
    logic [2:0]       r_idx;
    logic [2:0]       r_drv;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [3:0]       r_err;
    logic [CNT_W-1:0] r_max;

    state_t           w_state;
    logic [CNT_W-1:0] w_lat;
    logic [2:0]       w_idx;
    logic [2:0]       w_drv;
    logic             w_busy;
    logic             w_done;
    logic             w_pass;
    logic [3:0]       w_err;
    logic [CNT_W-1:0] w_max;
    logic             w_exp;
    logic             w_match;
    logic             w_tmo;

    // {a,b,c} per vector; every odd entry is 000 so expected Y alternates
    function automatic logic [2:0] vec_tbl(input logic [2:0] i);
        logic [2:0] v;
        v = 3'b000;
        case (i)
            3'd0:    v = 3'b001;
            3'd2:    v = 3'b010;
            3'd4:    v = 3'b100;
            3'd6:    v = 3'b111;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    assign w_exp   = ~(|r_drv);
    assign w_match = (r_sync2 == w_exp);
    assign w_tmo   = !w_match && (r_lat == LAT_TMO);

    // Two-flop synchronizer for the asynchronous cell output
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= y_in;
            r_sync2 <= r_sync1;
        end
    end

    // State and result registers
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_state <= S_IDLE;
            r_lat   <= '0;
            r_idx   <= '0;
            r_drv   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_max   <= '0;
        end else begin
            r_state <= w_state;
            r_lat   <= w_lat;
            r_idx   <= w_idx;
            r_drv   <= w_drv;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_err   <= w_err;
            r_max   <= w_max;
        end
    end

    // Next-state: launch on start, then match-or-timeout per vector
    always_comb begin
        w_state = r_state;
        w_lat   = r_lat;
        w_idx   = r_idx;
        w_drv   = r_drv;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_pass  = r_pass;
        w_err   = r_err;
        w_max   = r_max;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_WAIT;
                    w_idx   = 3'd0;
                    w_drv   = vec_tbl(3'd0);
                    w_lat   = '0;
                    w_busy  = 1'b1;
                    w_err   = '0;
                    w_max   = '0;
                    w_pass  = 1'b0;
                end
            end
            S_WAIT: begin
                if (w_match || w_tmo) begin
                    if (w_match) begin
                        if (r_lat > r_max) w_max = r_lat;
                    end else begin
                        w_err = r_err + 4'd1;
                    end
                    if (r_idx != 3'd7) begin
                        w_idx = r_idx + 3'd1;
                        w_drv = vec_tbl(r_idx + 3'd1);
                        w_lat = '0;
                    end else begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_pass  = (w_err == 4'd0);
                    end
                end else begin
                    w_lat = r_lat + 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign drv_a     = r_drv[2];
    assign drv_b     = r_drv[1];
    assign drv_c     = r_drv[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign max_lat   = r_max;
    assign vec_idx   = r_idx;

endmodule
